instruction_fetch_stage: RTL and testbench
==========================================

// Module: instruction_fetch_stage
// PURPOSE
//  IF stage of the 5-stage MIPS pipeline, directly upstream of the IF/ID register.
//  Holds the PC, the program instruction memory and a load/run/halt control FSM.
//  Drives the IF/ID register each cycle with the fetched instruction and PC+4.
//  Next-PC sources are sequential, branch (from ID) and jump (from ID). Stalls come from the hazard unit.
// PARAMETERS
//  DEPTH        64        instruction memory depth in 32-bit words (power of 2)
//  NOP          32'h0     instruction word driven while not fetching
//  HALT_OPCODE  6'h3F     opcode [31:26] recognised as HALT (see CONFIGURATION)
//  (localparam ADDR_W = $clog2(DEPTH))
// PORTS
//  Clock           in   1       rising-edge clock
//  Reset           in   1       synchronous reset, active-low
//  Enable          in   1       PC write enable from hazard unit; 0 = stall (hold PC)
//  StepMode        in   1       1 = PC advances only on Step pulse
//  Step            in   1       single-step pulse (one cycle), used when StepMode=1
//  Start           in   1       leave LOAD/HALT and run from PC=0
//  LoadEn          in   1       program write strobe (LOAD state only)
//  LoadAddr        in   ADDR_W  word address for program write
//  LoadData        in   32      instruction word to write
//  PCSrc           in   1       branch taken
//  BranchTarget    in   32      branch target byte address
//  Jump            in   1       jump taken
//  JumpTarget      in   32      jump target byte address
//  Out_Instruction out  32      instruction for IF/ID In_Instruction
//  Out_PCAdder     out  32      PC+4 for IF/ID In_PCAdder
//  Out_PC          out  32      current PC (debug)
//  Out_Halted      out  1       1 while in HALT state
// BEHAVIOUR
//  - Reset (Reset==0 at a rising edge): state=LOAD, PC=0, Out_Halted=0. Memory contents are not cleared.
//  - FSM states: LOAD, RUN and HALT.
//    LOAD->RUN on Start (PC=0).
//    RUN->HALT on a fetched HALT (macro only).
//    HALT->RUN on Start (PC=0).
//    Start in RUN is ignored.
//  - LOAD: a LoadEn edge writes mem[LoadAddr]=LoadData. Out_Instruction=NOP. PC held at 0.
//    LoadEn together with Start: the write completes and the FSM enters RUN on the same edge.
//  - RUN: Out_Instruction = mem[PC[ADDR_W+1:2]] (combinational read, zero latency).
//    LoadEn is ignored.
//  - Advance condition: Enable && (!StepMode || Step).
//    If the condition is false, PC holds and the branch/jump request is dropped.
//  - Next-PC priority when advancing: Jump > PCSrc > PC+4.
//    Target bits [1:0] are forced to 0.
//  - Out_PCAdder = PC+4 (32-bit, wraps at 2^32). Out_PC = PC.
//  - Memory index uses PC[ADDR_W+1:2], so addresses beyond DEPTH*4 wrap modulo DEPTH. PC itself is not truncated.
//  - HALT: PC frozen, Out_Instruction=NOP, Out_Halted=1. Enable, Step, PCSrc and Jump are ignored.
//  - Reset mid-RUN/HALT: returns to LOAD next edge. The program is retained. Start reruns from 0.
// CONFIGURATION
//  IF_HALT_DETECT_EN defined:
//   - In RUN, if the fetched word has [31:26]==HALT_OPCODE, the word is presented once so it drains down the pipe.
//   - On the next advancing edge: state=HALT and PC is not updated.
//   - While stalled on the HALT word, the FSM stays in RUN.
//  IF_HALT_DETECT_EN undefined:
//   - The HALT opcode is an ordinary word and HALT is unreachable.
//   - Out_Halted is tied to 0. Start still acts only from LOAD.
// STRUCTURE
//  Shared package/header (fetch_pkg): FSM state encoding (LOAD/RUN/HALT), NOP, HALT_OPCODE, word-align helper.
//  One sub-module: instr_mem (DEPTH x 32, synchronous write port, asynchronous read port).
//  The top level holds the PC register, the next-PC mux and the FSM.
// TESTING
//  T1 reset/load:
//   - Reset=0 one edge -> PC=0, Out_Instruction=0, Out_Halted=0.
//   - Write 0x20080005 @0 and 0x20090007 @1, then Start.
//   - Expect Out_Instruction=0x20080005, Out_PCAdder=4; next edge PC=4, Out_Instruction=0x20090007.
//  T2 stall:
//   - RUN at PC=8, Enable=0 for 3 edges -> PC stays 8, Out_Instruction constant.
//   - Enable=1 -> PC=12.
//  T3 redirect priority:
//   - PC=16, PCSrc=1 with BranchTarget=0x40, Jump=1 with JumpTarget=0x83 -> PC=0x80.
//   - Next: PCSrc=1 with Enable=0 -> PC held, branch dropped.
//  T4 step mode:
//   - StepMode=1, Enable=1, no Step for 4 edges -> PC unchanged.
//   - One Step pulse -> PC+4 exactly once.
//  T5 halt (macro on):
//   - HALT word 0xFC000000 @3 -> presented at PC=12.
//   - Next edge Out_Halted=1, PC=12, Out_Instruction=0.
//   - Start -> PC=0, RUN. With the macro off: PC=16, Out_Halted=0.
//  T6 wrap/reset:
//   - Jump to 0x100 with DEPTH=64 -> fetches mem[0].
//   - Reset mid-RUN -> LOAD with the program retained; Start refetches word 0.

Source files
------------

// File: rtl/instruction_fetch_stage_pkg.sv
// Shared definitions for the MIPS IF stage: FSM encoding, fixed words and PC alignment.
package instruction_fetch_stage_pkg;

   localparam int unsigned WORD_W    = 32;
   localparam int unsigned OPC_W     = 6;
   localparam int unsigned DEF_DEPTH = 64;

   localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0000;
   localparam logic [OPC_W-1:0]  HALT_OPC = 6'h3F;

   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } fetch_state_e;

   // Redirect targets are byte addresses; fetch only ever uses word-aligned PCs.
   function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
      return {addr[WORD_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Control, program-load, redirect and IF/ID-facing signals of the fetch stage.
interface instruction_fetch_stage_if #(
   parameter int unsigned DEPTH = 64
) ();
   localparam int unsigned ADDR_W = $clog2(DEPTH);

   logic              Enable;
   logic              StepMode;
   logic              Step;
   logic              Start;
   logic              LoadEn;
   logic [ADDR_W-1:0] LoadAddr;
   logic [31:0]       LoadData;
   logic              PCSrc;
   logic [31:0]       BranchTarget;
   logic              Jump;
   logic [31:0]       JumpTarget;
   logic [31:0]       Out_Instruction;
   logic [31:0]       Out_PCAdder;
   logic [31:0]       Out_PC;
   logic              Out_Halted;

   modport master (
      output Enable, StepMode, Step, Start, LoadEn, LoadAddr, LoadData,
             PCSrc, BranchTarget, Jump, JumpTarget,
      input  Out_Instruction, Out_PCAdder, Out_PC, Out_Halted
   );

   modport slave (
      input  Enable, StepMode, Step, Start, LoadEn, LoadAddr, LoadData,
             PCSrc, BranchTarget, Jump, JumpTarget,
      output Out_Instruction, Out_PCAdder, Out_PC, Out_Halted
   );
endinterface

// File: rtl/instruction_fetch_stage_instr_mem.sv
// Program memory: DEPTH x 32, synchronous write, asynchronous (zero-latency) read.
module instruction_fetch_stage_instr_mem #(
   parameter int unsigned DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [31:0]              wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [31:0]              rdata_o
);
   logic [31:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/instruction_fetch_stage.sv
// IF stage: PC register, next-PC mux and LOAD/RUN/HALT control around the program memory.
// HALT detection of fetched words is built only when IF_HALT_DETECT_EN is defined.
module instruction_fetch_stage
   import instruction_fetch_stage_pkg::*;
#(
   parameter int unsigned DEPTH = DEF_DEPTH,
   parameter logic [31:0] NOP   = NOP_WORD
`ifdef IF_HALT_DETECT_EN
   ,
   parameter logic [5:0]  HALT_OPCODE = HALT_OPC
`endif
) (
   input  logic                      Clock,
   input  logic                      Reset,
   instruction_fetch_stage_if.slave  bus
);
   localparam int unsigned ADDR_W = $clog2(DEPTH);

   fetch_state_e      state_q;
   logic [31:0]       pc_q;
   logic [31:0]       pc_d;
   logic [31:0]       pc_plus4;
   logic [31:0]       mem_rdata;
   logic              mem_we;
   logic              advance;
   logic              halt_hit;

   // Writes only land while loading; reset blocks them.
   assign mem_we = Reset && (state_q == ST_LOAD) && bus.LoadEn;

   instruction_fetch_stage_instr_mem #(.DEPTH(DEPTH)) u_mem (
      .clk     (Clock),
      .we_i    (mem_we),
      .waddr_i (bus.LoadAddr),
      .wdata_i (bus.LoadData),
      .raddr_i (pc_q[ADDR_W+1:2]),
      .rdata_o (mem_rdata)
   );

   assign pc_plus4 = pc_q + 32'd4;
   assign advance  = bus.Enable && (!bus.StepMode || bus.Step);

`ifdef IF_HALT_DETECT_EN
   assign halt_hit = (mem_rdata[31:26] == HALT_OPCODE);
`else
   assign halt_hit = 1'b0;
`endif

   // Next PC when advancing: jump beats branch beats sequential.
   always_comb begin
      pc_d = pc_plus4;
      if (bus.Jump)       pc_d = word_align(bus.JumpTarget);
      else if (bus.PCSrc) pc_d = word_align(bus.BranchTarget);
   end

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state_q <= ST_LOAD;
         pc_q    <= 32'd0;
      end else begin
         case (state_q)
            ST_LOAD: begin
               if (bus.Start) begin
                  state_q <= ST_RUN;
                  pc_q    <= 32'd0;
               end
            end
            ST_RUN: begin
               // A HALT word has already been presented once; freeze on it.
               if (advance) begin
                  if (halt_hit) state_q <= ST_HALT;
                  else          pc_q    <= pc_d;
               end
            end
            ST_HALT: begin
               if (bus.Start) begin
                  state_q <= ST_RUN;
                  pc_q    <= 32'd0;
               end
            end
            default: begin
               state_q <= ST_LOAD;
               pc_q    <= 32'd0;
            end
         endcase
      end
   end

   assign bus.Out_Instruction = (state_q == ST_RUN) ? mem_rdata : NOP;
   assign bus.Out_PCAdder     = pc_plus4;
   assign bus.Out_PC          = pc_q;
   assign bus.Out_Halted      = (state_q == ST_HALT);
endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed + randomized bench for instruction_fetch_stage against a behavioural model.
// Honours IF_HALT_DETECT_EN the same way as the design.
module tb_instruction_fetch_stage;
   localparam int unsigned DEPTH = 64;
   localparam int M_LOAD = 0;
   localparam int M_RUN  = 1;
   localparam int M_HALT = 2;

   logic Clock;
   logic Reset;

   instruction_fetch_stage_if #(.DEPTH(DEPTH)) bus ();

   instruction_fetch_stage dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] m_mem [DEPTH];
   int          m_state = M_LOAD;
   logic [31:0] m_pc = 32'd0;

`ifdef IF_HALT_DETECT_EN
   localparam bit HALT_EN = 1'b1;
`else
   localparam bit HALT_EN = 1'b0;
`endif

   // Reference behaviour of one rising edge, from the current input values.
   task automatic model_edge();
      logic [31:0] fetched;
      if (!Reset) begin
         m_state = M_LOAD;
         m_pc    = 32'd0;
      end else if (m_state == M_LOAD) begin
         if (bus.LoadEn) m_mem[int'(bus.LoadAddr)] = bus.LoadData;
         if (bus.Start) begin m_state = M_RUN; m_pc = 32'd0; end
      end else if (m_state == M_HALT) begin
         if (bus.Start) begin m_state = M_RUN; m_pc = 32'd0; end
      end else if (bus.Enable && (!bus.StepMode || bus.Step)) begin
         fetched = m_mem[(m_pc / 4) % DEPTH];
         if (HALT_EN && fetched[31:26] == 6'h3F) m_state = M_HALT;
         else if (bus.Jump)  m_pc = bus.JumpTarget & 32'hFFFF_FFFC;
         else if (bus.PCSrc) m_pc = bus.BranchTarget & 32'hFFFF_FFFC;
         else                m_pc = m_pc + 32'd4;
      end
   endtask

   task automatic expect_word(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic check_model(input string tag);
      logic [31:0] e_instr;
      e_instr = (m_state == M_RUN) ? m_mem[(m_pc / 4) % DEPTH] : 32'h0;
      expect_word({tag, ".pc"},     bus.Out_PC, m_pc);
      expect_word({tag, ".instr"},  bus.Out_Instruction, e_instr);
      expect_word({tag, ".pcadd"},  bus.Out_PCAdder, m_pc + 32'd4);
      expect_word({tag, ".halted"}, 32'(bus.Out_Halted), 32'(m_state == M_HALT));
   endtask

   task automatic tick(input string tag);
      @(posedge Clock);
      model_edge();
      #1;
      check_model(tag);
   endtask

   task automatic idle_inputs();
      bus.Enable = 1'b0; bus.StepMode = 1'b0; bus.Step = 1'b0; bus.Start = 1'b0;
      bus.LoadEn = 1'b0; bus.LoadAddr = '0; bus.LoadData = 32'h0;
      bus.PCSrc = 1'b0; bus.BranchTarget = 32'h0; bus.Jump = 1'b0; bus.JumpTarget = 32'h0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] w;
      idle_inputs();
      Reset = 1'b0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;

      // T1 reset and program load
      #2;
      tick("reset");
      expect_word("reset.pc_const", bus.Out_PC, 32'h0);
      Reset = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         w = $urandom();
         if (w[31:26] == 6'h3F) w[31] = 1'b0;
         if (i == 0) w = 32'h2008_0005;
         if (i == 1) w = 32'h2009_0007;
         if (i == 3) w = 32'hFC00_0000;
         bus.LoadEn = 1'b1; bus.LoadAddr = 6'(i); bus.LoadData = w;
         tick("load");
      end
      bus.LoadEn = 1'b0; bus.Start = 1'b1;
      tick("start");
      expect_word("t1.instr0", bus.Out_Instruction, 32'h2008_0005);
      expect_word("t1.pcadd0", bus.Out_PCAdder, 32'd4);
      bus.Start = 1'b0; bus.Enable = 1'b1;
      tick("run1");
      expect_word("t1.instr1", bus.Out_Instruction, 32'h2009_0007);
      tick("run2");

      // T2 stall
      bus.Enable = 1'b0;
      for (int i = 0; i < 3; i++) tick("stall");
      expect_word("t2.held", bus.Out_PC, 32'd8);
      bus.Enable = 1'b1;
      tick("unstall");
      expect_word("t2.pc12", bus.Out_PC, 32'd12);

      // T5 halt word at 12
      tick("halt");
`ifdef IF_HALT_DETECT_EN
      expect_word("t5.halted_pc", bus.Out_PC, 32'd12);
      expect_word("t5.halted", 32'(bus.Out_Halted), 32'd1);
`else
      expect_word("t5.nohalt_pc", bus.Out_PC, 32'd16);
`endif
      bus.Enable = 1'b0; bus.Start = 1'b1;
      tick("restart");
      bus.Start = 1'b0;

      // T3 redirect priority and dropped branch
      bus.Enable = 1'b1; bus.Jump = 1'b1; bus.JumpTarget = 32'd16;
      tick("jump16");
      bus.PCSrc = 1'b1; bus.BranchTarget = 32'h40; bus.JumpTarget = 32'h83;
      tick("prio");
      expect_word("t3.prio", bus.Out_PC, 32'h80);
      bus.Jump = 1'b0; bus.Enable = 1'b0;
      tick("drop");
      expect_word("t3.drop", bus.Out_PC, 32'h80);
      bus.PCSrc = 1'b0; bus.Enable = 1'b1;
      tick("seq");
      expect_word("t3.seq", bus.Out_PC, 32'h84);

      // T4 step mode
      bus.StepMode = 1'b1;
      for (int i = 0; i < 4; i++) tick("nostep");
      bus.Step = 1'b1;
      tick("step");
      expect_word("t4.step", bus.Out_PC, 32'h88);
      bus.Step = 1'b0;
      tick("afterstep");
      bus.StepMode = 1'b0;

      // T6 address wrap and reset mid-run
      bus.Jump = 1'b1; bus.JumpTarget = 32'h100;
      tick("wrap");
      expect_word("t6.wrap", bus.Out_Instruction, 32'h2008_0005);
      bus.Jump = 1'b0;
      Reset = 1'b0;
      tick("midreset");
      Reset = 1'b1; bus.Start = 1'b1;
      tick("rerun");
      expect_word("t6.rerun", bus.Out_Instruction, 32'h2008_0005);
      bus.Start = 1'b0;

      // Randomized operation, including reloads of HALT words and restarts
      for (int n = 0; n < 500; n++) begin
         Reset          = ($urandom_range(0, 79) != 0);
         bus.Start      = ($urandom_range(0, 14) == 0);
         bus.LoadEn     = Reset && ($urandom_range(0, 1) == 1);
         bus.LoadAddr   = 6'($urandom_range(0, DEPTH - 1));
         w              = $urandom();
         if ($urandom_range(0, 7) == 0) w[31:26] = 6'h3F;
         bus.LoadData   = w;
         bus.Enable     = ($urandom_range(0, 3) != 0);
         bus.StepMode   = ($urandom_range(0, 3) == 0);
         bus.Step       = ($urandom_range(0, 1) == 1);
         bus.PCSrc      = ($urandom_range(0, 3) == 0);
         bus.BranchTarget = $urandom();
         bus.Jump       = ($urandom_range(0, 5) == 0);
         bus.JumpTarget = $urandom();
         tick("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
